// File: rtl/datapath_pkg.sv
// Shared types and constants for the datapath: bus width, ALU opcodes and CON condition codes.
// The optional multiplier/divider is enabled by defining DATAPATH_MULDIV_EN.
package datapath_pkg;

    localparam int BUS_W = 32;
    localparam int NUM_REGS = 16;

    typedef enum logic [4:0] {
        OP_ADD   = 5'b00000,
        OP_ADD_1 = 5'b00001,
        OP_ADD_3 = 5'b00011,
        OP_SUB   = 5'b00100,
        OP_AND   = 5'b00101,
        OP_OR    = 5'b00110,
        OP_SHR   = 5'b00111,
        OP_SHRA  = 5'b01000,
        OP_SHL   = 5'b01001,
        OP_ROR   = 5'b01010,
        OP_ROL   = 5'b01011,
        OP_ADDI  = 5'b01100,
        OP_ANDI  = 5'b01101,
        OP_ORI   = 5'b01110,
        OP_MUL   = 5'b01111,
        OP_DIV   = 5'b10000,
        OP_NEG   = 5'b10001,
        OP_NOT   = 5'b10010
    } op_e;

    typedef enum logic [1:0] {
        CON_EQ0 = 2'b00,
        CON_NE0 = 2'b01,
        CON_GE0 = 2'b10,
        CON_LT0 = 2'b11
    } con_e;

    function automatic logic con_eval(input logic [1:0] cond, input logic [BUS_W-1:0] value);
        logic hit;
        hit = 1'b0;
        case (con_e'(cond))
            CON_EQ0: hit = (value == '0);
            CON_NE0: hit = (value != '0);
            CON_GE0: hit = ~value[BUS_W-1];
            CON_LT0: hit = value[BUS_W-1];
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A and B in, 64-bit result out. Mul/div exist only when
// DATAPATH_MULDIV_EN is defined; otherwise those opcodes produce zero.
module alu
    import datapath_pkg::*;
(
    input  logic [BUS_W-1:0]   a,
    input  logic [BUS_W-1:0]   b,
    input  logic [4:0]         opcode,
    output logic [2*BUS_W-1:0] result
);

    op_e              op;
    logic [4:0]       amt;
    logic [5:0]       amt_inv;
    logic [BUS_W-1:0] low;

`ifdef DATAPATH_MULDIV_EN
    logic [2*BUS_W-1:0]      a_ext;
    logic [2*BUS_W-1:0]      b_ext;
    logic [2*BUS_W-1:0]      product;
    logic signed [BUS_W-1:0] quotient;
    logic signed [BUS_W-1:0] remainder;
`endif

    assign op      = op_e'(opcode);
    assign amt     = b[4:0];
    assign amt_inv = 6'd32 - {1'b0, amt};

`ifdef DATAPATH_MULDIV_EN
    // Sign-extending both operands makes the low 64 bits of an unsigned product the signed product.
    assign a_ext   = {{BUS_W{a[BUS_W-1]}}, a};
    assign b_ext   = {{BUS_W{b[BUS_W-1]}}, b};
    assign product = a_ext * b_ext;

    always_comb begin
        quotient  = '0;
        remainder = $signed(a);
        if (b != '0) begin
            quotient  = $signed(a) / $signed(b);
            remainder = $signed(a) % $signed(b);
        end
    end
`endif

    always_comb begin
        low = a + b;
        case (op)
            OP_SUB:          low = a - b;
            OP_AND, OP_ANDI: low = a & b;
            OP_OR,  OP_ORI:  low = a | b;
            OP_SHR:          low = a >> amt;
            OP_SHRA:         low = $signed(a) >>> amt;
            OP_SHL:          low = a << amt;
            OP_ROR:          low = (a >> amt) | (a << amt_inv);
            OP_ROL:          low = (a << amt) | (a >> amt_inv);
            OP_NEG:          low = -b;
            OP_NOT:          low = ~b;
            default:         low = a + b;
        endcase

        result = {{BUS_W{low[BUS_W-1]}}, low};
`ifdef DATAPATH_MULDIV_EN
        if (op == OP_MUL) begin
            result = product;
        end else if (op == OP_DIV) begin
            result = {remainder, quotient};
        end
`else
        if (op == OP_MUL || op == OP_DIV) begin
            result = '0;
        end
`endif
    end

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: register file, special registers, bus mux, IR select/encode and CON logic.
// Define DATAPATH_MULDIV_EN to build the ALU with signed multiply and divide.
module datapath
    import datapath_pkg::*;
(
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Read,
    input  logic                Write,
    input  logic                IncPC,
    input  logic [NUM_REGS-1:0] R0_15_enable,
    input  logic [NUM_REGS-1:0] R0_15_out,
    input  logic                PCin,
    input  logic                Zin,
    input  logic                MDRin,
    input  logic                MARin,
    input  logic                Yin,
    input  logic                HIin,
    input  logic                LOin,
    input  logic                IRin,
    input  logic                OutPortin,
    input  logic                PCout,
    input  logic                Zhighout,
    input  logic                Zlowout,
    input  logic                HIout,
    input  logic                LOout,
    input  logic                MDRout,
    input  logic                InPortout,
    input  logic                Cout,
    input  logic                BAout,
    input  logic                CONin,
    input  logic                Gra,
    input  logic                Grb,
    input  logic                Grc,
    input  logic                Rin,
    input  logic                Rout,
    input  logic [BUS_W-1:0]    InPort_input,
    input  logic [BUS_W-1:0]    Mdatain,
    output logic [BUS_W-1:0]    OutPort_out,
    output logic                CON_out,
    output logic [BUS_W-1:0]    MAR_out,
    output logic [BUS_W-1:0]    MDR_out,
    output logic                Mem_write
);

    logic [BUS_W-1:0]   pc_q, pc_d;
    logic [BUS_W-1:0]   ir_q, ir_d;
    logic [BUS_W-1:0]   mar_q, mar_d;
    logic [BUS_W-1:0]   mdr_q, mdr_d;
    logic [BUS_W-1:0]   y_q, y_d;
    logic [2*BUS_W-1:0] z_q, z_d;
    logic [BUS_W-1:0]   hi_q, hi_d;
    logic [BUS_W-1:0]   lo_q, lo_d;
    logic [BUS_W-1:0]   inport_q, inport_d;
    logic [BUS_W-1:0]   outport_q, outport_d;
    logic               con_q, con_d;
    logic [BUS_W-1:0]   regs_q [NUM_REGS];
    logic [BUS_W-1:0]   regs_d [NUM_REGS];

    logic [NUM_REGS-1:0] sel_onehot;
    logic [NUM_REGS-1:0] reg_drive;
    logic [NUM_REGS-1:0] reg_load;
    logic [BUS_W-1:0]    reg_val [NUM_REGS];
    logic                ba_zero;
    logic [BUS_W-1:0]    c_sext;
    logic [BUS_W-1:0]    bus;
    logic [2*BUS_W-1:0]  alu_result;

    // Each IR field decodes to a one-hot register select; enabled fields OR together.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_sel
            assign sel_onehot[gi] = (Gra && ir_q[26:23] == 4'(gi))
                                 || (Grb && ir_q[22:19] == 4'(gi))
                                 || (Grc && ir_q[18:15] == 4'(gi));
            if (gi == 0) begin : g_r0
                assign reg_val[gi] = ba_zero ? '0 : regs_q[gi];
            end else begin : g_rn
                assign reg_val[gi] = regs_q[gi];
            end
        end
    endgenerate

    assign ba_zero   = BAout && sel_onehot[0];
    assign reg_drive = R0_15_out | ({NUM_REGS{Rout | BAout}} & sel_onehot);
    assign reg_load  = R0_15_enable | ({NUM_REGS{Rin}} & sel_onehot);
    assign c_sext    = {{(BUS_W-19){ir_q[18]}}, ir_q[18:0]};

    // Lowest-priority sources are applied first so higher-priority drivers overwrite them.
    always_comb begin
        bus = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (reg_drive[i]) begin
                bus = reg_val[i];
            end
        end
        if (Cout)      bus = c_sext;
        if (InPortout) bus = inport_q;
        if (LOout)     bus = lo_q;
        if (HIout)     bus = hi_q;
        if (Zhighout)  bus = z_q[2*BUS_W-1:BUS_W];
        if (Zlowout)   bus = z_q[BUS_W-1:0];
        if (PCout)     bus = pc_q;
        if (MDRout)    bus = mdr_q;
    end

    alu u_alu (
        .a      (y_q),
        .b      (bus),
        .opcode (ir_q[31:27]),
        .result (alu_result)
    );

    always_comb begin
        pc_d      = pc_q;
        ir_d      = IRin      ? bus        : ir_q;
        mar_d     = MARin     ? bus        : mar_q;
        mdr_d     = mdr_q;
        y_d       = Yin       ? bus        : y_q;
        z_d       = Zin       ? alu_result : z_q;
        hi_d      = HIin      ? bus        : hi_q;
        lo_d      = LOin      ? bus        : lo_q;
        outport_d = OutPortin ? bus        : outport_q;
        con_d     = CONin     ? con_eval(ir_q[20:19], bus) : con_q;
        inport_d  = InPort_input;

        if (PCin) begin
            pc_d = IncPC ? pc_q + 32'd1 : bus;
        end
        if (MDRin) begin
            mdr_d = Read ? Mdatain : bus;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = reg_load[i] ? bus : regs_q[i];
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc_q      <= '0;
            ir_q      <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            y_q       <= '0;
            z_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            inport_q  <= '0;
            outport_q <= '0;
            con_q     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            y_q       <= y_d;
            z_q       <= z_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            inport_q  <= inport_d;
            outport_q <= outport_d;
            con_q     <= con_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign OutPort_out = outport_q;
    assign CON_out     = con_q;
    assign MAR_out     = mar_q;
    assign MDR_out     = mdr_q;
    assign Mem_write   = Write;

endmodule

// File: tb/tb_datapath.sv
// Directed-vector bench for datapath; registers are observed by routing them through OutPort.
module tb_datapath;

`ifdef DATAPATH_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Read, Write, IncPC;
    logic [15:0] R0_15_enable, R0_15_out;
    logic        PCin, Zin, MDRin, MARin, Yin, HIin, LOin, IRin, OutPortin;
    logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout, Cout, BAout;
    logic        CONin, Gra, Grb, Grc, Rin, Rout;
    logic [31:0] InPort_input = '0;
    logic [31:0] Mdatain = '0;
    logic [31:0] OutPort_out, MAR_out, MDR_out;
    logic        CON_out, Mem_write;

    int checks = 0;
    int errors = 0;

    datapath dut (
        .Clock(Clock), .Reset(Reset), .Read(Read), .Write(Write), .IncPC(IncPC),
        .R0_15_enable(R0_15_enable), .R0_15_out(R0_15_out),
        .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .IRin(IRin), .OutPortin(OutPortin),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .HIout(HIout),
        .LOout(LOout), .MDRout(MDRout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout),
        .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .InPort_input(InPort_input), .Mdatain(Mdatain),
        .OutPort_out(OutPort_out), .CON_out(CON_out), .MAR_out(MAR_out),
        .MDR_out(MDR_out), .Mem_write(Mem_write)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic clr();
        Read = 0; Write = 0; IncPC = 0; R0_15_enable = '0; R0_15_out = '0;
        PCin = 0; Zin = 0; MDRin = 0; MARin = 0; Yin = 0; HIin = 0; LOin = 0;
        IRin = 0; OutPortin = 0; PCout = 0; Zhighout = 0; Zlowout = 0; HIout = 0;
        LOout = 0; MDRout = 0; InPortout = 0; Cout = 0; BAout = 0; CONin = 0;
        Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        clr();
    endtask

    // Captures v into InPort, then leaves InPortout asserted for the caller's load cycle.
    task automatic put_bus(input logic [31:0] v);
        InPort_input = v;
        tick();
        InPortout = 1;
    endtask

    task automatic load_reg(input int i, input logic [31:0] v);
        put_bus(v);
        R0_15_enable = 16'(1 << i);
        tick();
    endtask

    task automatic probe_reg(input string tag, input int i, input logic [31:0] exp);
        R0_15_out = 16'(1 << i);
        OutPortin = 1;
        tick();
        chk(tag, {32'b0, OutPort_out}, {32'b0, exp});
    endtask

    task automatic alu_run(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] lo, input logic [31:0] hi);
        put_bus({op, 27'b0}); IRin = 1; tick();
        put_bus(a); Yin = 1; tick();
        put_bus(b); Zin = 1; tick();
        Zlowout = 1; OutPortin = 1; tick();
        chk({tag, "_lo"}, {32'b0, OutPort_out}, {32'b0, lo});
        Zhighout = 1; OutPortin = 1; tick();
        chk({tag, "_hi"}, {32'b0, OutPort_out}, {32'b0, hi});
    endtask

    task automatic con_run(input string tag, input logic [31:0] ir, input logic [31:0] v,
                           input logic exp);
        put_bus(ir); IRin = 1; tick();
        put_bus(v); CONin = 1; tick();
        chk(tag, {63'b0, CON_out}, {63'b0, exp});
    endtask

    initial begin
        clr();
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_outport", {32'b0, OutPort_out}, 64'h0);
        chk("rst_con", {63'b0, CON_out}, 64'h0);
        chk("rst_mar", {32'b0, MAR_out}, 64'h0);
        chk("rst_mdr", {32'b0, MDR_out}, 64'h0);
        chk("rst_memwr", {63'b0, Mem_write}, 64'h0);
        Reset = 0;

        // Instruction fetch
        put_bus(32'd7); PCin = 1; tick();
        PCout = 1; MARin = 1; tick();
        chk("fetch_mar", {32'b0, MAR_out}, 64'd7);
        Mdatain = 32'h18A0_0000; Read = 1; MDRin = 1; tick();
        chk("fetch_mdr", {32'b0, MDR_out}, 64'h18A0_0000);
        MDRout = 1; IRin = 1; PCin = 1; IncPC = 1; tick();
        PCout = 1; OutPortin = 1; tick();
        chk("fetch_pc", {32'b0, OutPort_out}, 64'd8);
        // IR ra field of 0x18A00000 is R1; R0 holds a different value to tell them apart.
        load_reg(0, 32'h0000_1111);
        load_reg(1, 32'h0000_ABCD);
        Gra = 1; Rout = 1; OutPortin = 1; tick();
        chk("fetch_ir_ra", {32'b0, OutPort_out}, 64'hABCD);

        put_bus(32'h1234_5678); MDRin = 1; tick();
        chk("mdr_from_bus", {32'b0, MDR_out}, 64'h1234_5678);
        Write = 1; #1;
        chk("mem_write", {63'b0, Mem_write}, 64'h1);
        Write = 0;

        // addi: 0x6118FFFE has IR[18]=0 so C=0x0FFFE; 0x611FFFFE encodes C=-2
        load_reg(3, 32'd5);
        put_bus(32'h6118_FFFE); IRin = 1; tick();
        Grb = 1; Rout = 1; Yin = 1; tick();
        Cout = 1; Zin = 1; tick();
        Zlowout = 1; Gra = 1; Rin = 1; tick();
        probe_reg("addi_c0fffe", 2, 32'h0001_0003);
        put_bus(32'h611F_FFFE); IRin = 1; tick();
        Grb = 1; Rout = 1; Yin = 1; tick();
        Cout = 1; Zin = 1; tick();
        Zlowout = 1; Gra = 1; Rin = 1; tick();
        probe_reg("addi_neg2", 2, 32'd3);

        // Bus priority and encode
        MDRout = 1; PCout = 1; OutPortin = 1; tick();
        chk("prio_mdr_pc", {32'b0, OutPort_out}, 64'h1234_5678);
        R0_15_out = 16'h0003; OutPortin = 1; tick();
        chk("prio_r0_r1", {32'b0, OutPort_out}, 64'h1111);
        OutPortin = 1; tick();
        chk("bus_idle", {32'b0, OutPort_out}, 64'h0);
        put_bus(32'h0); IRin = 1; tick();
        Grb = 1; BAout = 1; OutPortin = 1; tick();
        chk("baout_r0", {32'b0, OutPort_out}, 64'h0);
        Grb = 1; Rout = 1; OutPortin = 1; tick();
        chk("rout_r0", {32'b0, OutPort_out}, 64'h1111);
        put_bus(32'h0018_0000); IRin = 1; tick();
        Grb = 1; BAout = 1; OutPortin = 1; tick();
        chk("baout_r3", {32'b0, OutPort_out}, 64'd5);
        put_bus(32'h0007_FFFE); IRin = 1; tick();
        Cout = 1; OutPortin = 1; tick();
        chk("cout_neg", {32'b0, OutPort_out}, 64'hFFFF_FFFE);
        put_bus(32'h0003_FFFF); IRin = 1; tick();
        Cout = 1; OutPortin = 1; tick();
        chk("cout_pos", {32'b0, OutPort_out}, 64'h0003_FFFF);

        // CON
        con_run("con_eq0_0", 32'h0000_0000, 32'd0, 1'b1);
        con_run("con_eq0_1", 32'h0000_0000, 32'd1, 1'b0);
        con_run("con_ne0_7", 32'h0008_0000, 32'd7, 1'b1);
        con_run("con_ge0_neg", 32'h0010_0000, 32'h8000_0000, 1'b0);
        con_run("con_lt0_neg", 32'h0018_0000, 32'h8000_0000, 1'b1);
        con_run("con_lt0_1", 32'h0018_0000, 32'd1, 1'b0);

        // ALU
        alu_run("add_ovf", 5'b00000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF);
        alu_run("sub", 5'b00100, 32'd3, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        alu_run("and", 5'b00101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 32'h0);
        alu_run("or", 5'b01110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 32'hFFFF_FFFF);
        alu_run("shr", 5'b00111, 32'h8000_0000, 32'd4, 32'h0800_0000, 32'h0);
        alu_run("shra", 5'b01000, 32'h8000_0000, 32'd4, 32'hF800_0000, 32'hFFFF_FFFF);
        alu_run("shl_amt33", 5'b01001, 32'd1, 32'd33, 32'd2, 32'h0);
        alu_run("ror", 5'b01010, 32'd1, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF);
        alu_run("rol", 5'b01011, 32'h8000_0001, 32'd4, 32'h0000_0018, 32'h0);
        alu_run("neg", 5'b10001, 32'd9, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        alu_run("not", 5'b10010, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        alu_run("dflt_add", 5'b11111, 32'd2, 32'd3, 32'd5, 32'h0);
        alu_run("div_7_m2", 5'b10000, 32'd7, 32'hFFFF_FFFE,
                MD ? 32'hFFFF_FFFD : 32'h0, MD ? 32'd1 : 32'h0);
        alu_run("div_by0", 5'b10000, 32'd9, 32'd0, 32'h0, MD ? 32'd9 : 32'h0);
        alu_run("mul", 5'b01111, 32'hFFFF_FFFF, 32'd6,
                MD ? 32'hFFFF_FFFA : 32'h0, MD ? 32'hFFFF_FFFF : 32'h0);
        Zhighout = 1; HIin = 1; tick();
        Zlowout = 1; LOin = 1; tick();
        HIout = 1; OutPortin = 1; tick();
        chk("hi_from_z", {32'b0, OutPort_out}, {32'b0, MD ? 32'hFFFF_FFFF : 32'h0});
        LOout = 1; OutPortin = 1; tick();
        chk("lo_from_z", {32'b0, OutPort_out}, {32'b0, MD ? 32'hFFFF_FFFA : 32'h0});

        // Reset between Zin and Zlowout; Z would otherwise hold 7
        put_bus(32'h0); IRin = 1; tick();
        put_bus(32'd4); Yin = 1; tick();
        put_bus(32'd3); Zin = 1; tick();
        put_bus(32'h77); OutPortin = 1; tick();
        chk("pre_rst_outport", {32'b0, OutPort_out}, 64'h77);
        Reset = 1; #2;
        chk("async_rst_outport", {32'b0, OutPort_out}, 64'h0);
        chk("async_rst_mar", {32'b0, MAR_out}, 64'h0);
        Reset = 0;
        Zlowout = 1; R0_15_enable = 16'h0020; tick();
        probe_reg("rst_z_to_r5", 5, 32'h0);
        Zhighout = 1; OutPortin = 1; tick();
        chk("rst_zhigh", {32'b0, OutPort_out}, 64'h0);
        PCin = 1; IncPC = 1; tick();
        PCout = 1; OutPortin = 1; tick();
        chk("post_rst_pc", {32'b0, OutPort_out}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
